// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF-stage fetch FSM driving imem req/gnt/rvalid and a {pc, instr} FIFO for decode.
// Optional perf counters enabled with `define IFU_PERF_COUNTERS_EN.
module instr_fetch_unit #(
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_ld,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               id_ready
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic inflight_q, inflight_d, drop_q, drop_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] buf_pc_q [BUF_DEPTH];
  logic [INSTR_W-1:0] buf_instr_q [BUF_DEPTH];
  logic push, pop, can_issue;
  always_comb begin
    can_issue = (count_q + CW'(inflight_q)) < CW'(BUF_DEPTH);
    imem_req  = !Reset && state_q == REQ && !flush && can_issue;
    imem_addr = (!Reset && state_q == REQ) ? pc_in : '0;
    pc_ld     = !Reset && ((imem_req && imem_gnt) || flush);
    if_valid  = !Reset && count_q != '0;
    if_pc     = if_valid ? buf_pc_q[rd_q] : '0;
    if_instr  = if_valid ? buf_instr_q[rd_q] : '0;
    // A response racing a flush belongs to the old path, so it is never pushed.
    push      = state_q == WAIT && imem_rvalid && !drop_q && !flush;
    pop       = if_valid && id_ready && !flush;
    count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d      = flush ? '0 : wr_q + PW'(push);
    rd_d      = flush ? '0 : rd_q + PW'(pop);
    state_d    = state_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (imem_req && imem_gnt) begin
        req_pc_d   = pc_in;
        inflight_d = 1'b1;
        state_d    = WAIT;
      end
      WAIT: if (imem_rvalid) begin
        inflight_d = 1'b0;
        drop_d     = 1'b0;
        state_d    = REQ;
      end else if (flush) drop_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      req_pc_q   <= req_pc_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (push) begin
      buf_pc_q[wr_q]    <= req_pc_q;
      buf_instr_q[wr_q] <= imem_rdata;
    end
  end
  assert property (@(posedge Clk) disable iff (Reset) !(push && count_q == CW'(BUF_DEPTH)));
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;
  always_comb begin
    perf_fetch_d   = perf_fetch_q + 32'(push);
    perf_stall_d   = perf_stall_q + 32'(state_q != IDLE && !pc_ld);
    perf_fetch_cnt = perf_fetch_q;
    perf_stall_cnt = perf_stall_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF-stage engine that reads the current PC, fetches the instruction from instruction memory over a req/gnt/rvalid handshake, and buffers {pc, instr} pairs for decode.
- Drives the load-enable of the PC/nPC register pair. PC advances only when a fetch is accepted or a redirect occurs; all other cycles are a stall.
- Sits between the PC/nPC registers, the instruction memory port, and the ID pipeline register.

Parameters:
- ADDR_W, 32, width of PC and fetch address.
- INSTR_W, 32, instruction width.
- BUF_DEPTH, 2, fetch buffer entries (power of two, >= 2).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- pc_in  in  ADDR_W  current PC from the PC register.
- pc_ld  out  1  load enable to the PC/nPC registers (1 = advance; 0 = stall).
- flush  in  1  branch/jump redirect; external mux presents the target on the PC/nPC inputs this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  INSTR_W  fetched instruction.
- if_valid  out  1  buffer head valid.
- if_pc  out  ADDR_W  PC of head entry.
- if_instr  out  INSTR_W  instruction of head entry.
- id_ready  in  1  decode accepts head; a pop occurs when if_valid & id_ready.

Behaviour:
- Reset (Reset, synchronous, active-high; clock Clk):
  - state=IDLE, buffer count=0, inflight=0, drop=0.
  - All outputs 0: imem_req, imem_addr, pc_ld, if_valid, if_pc, if_instr.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ on the first cycle after Reset deasserts. imem_rvalid is ignored in IDLE.
  - REQ:
    - imem_req=1 when (count+inflight) < BUF_DEPTH and flush=0.
    - imem_addr=pc_in, combinational.
    - On imem_req & imem_gnt: capture pc_in into req_pc, set inflight=1, go to WAIT.
    - Without gnt: hold req and addr stable; PC stalls.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid: if drop=0, push {req_pc, imem_rdata}; if drop=1, discard. Then clear inflight and drop, and go to REQ.
- pc_ld = (imem_req & imem_gnt) | flush. It is a single-cycle pulse; PC/nPC update at the next edge.
- Latency:
  - Earliest gnt same cycle as req.
  - Earliest rvalid one cycle after gnt.
  - Entry visible on if_valid the cycle after rvalid.
  - Minimum issue-to-decode time is 2 cycles.
  - Sustained throughput is 1 fetch per 2 cycles.
- Buffer:
  - FIFO with registered outputs.
  - Head presented whenever count>0.
  - Push and pop in the same cycle leaves count unchanged.
  - Overflow is impossible by the issue rule. A push when count==BUF_DEPTH is a design error and must be caught by an assertion.
- Flush:
  - Clears the buffer (count=0); if_valid=0 from the next cycle.
  - Any pop in the flush cycle is ignored.
  - Suppresses imem_req in that cycle.
  - In WAIT: sets drop=1 so the in-flight response is discarded. If rvalid arrives in the same cycle as flush, that response is discarded.
  - In REQ: stays in REQ and fetches the new pc_in next cycle.
  - Back-to-back flushes: each flush reapplies the rules above.
- Reset mid-operation: overrides everything; an outstanding memory response after Reset is ignored because IDLE drops rvalid.
- Address: no alignment or wrap checks; pc_in is passed through unmodified. Address wrap at 2^ADDR_W is the PC logic's concern.

Optional Feature:
- Macro: IFU_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments on each push with drop=0.
  - perf_stall_cnt increments every post-IDLE cycle with pc_ld=0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset held 3 cycles, pc_in=0:
  - During Reset, all outputs are 0.
  - In the first REQ cycle, imem_req=1 and imem_addr=0x0.
- Memory always grants with 1-cycle response, id_ready=1, PC sequence 0,4,8:
  - if_pc shows 0x0, 0x4, 0x8 in order, one per 2 cycles.
  - if_instr matches imem_rdata.
  - pc_ld pulses once per fetch.
- id_ready=0, continuous grants:
  - Buffer fills to 2 and imem_req drops.
  - pc_ld stays 0 and pc_in holds at 0x8.
  - Raising id_ready resumes fetching.
- Gnt at pc 0x10, flush asserted in WAIT with target 0x40:
  - Response for 0x10 is discarded and the buffer is empty.
  - Next imem_addr=0x40 and pc_ld=1 in the flush cycle.
- flush asserted in the same cycle as imem_rvalid (pc 0x20):
  - No push occurs; if_valid=0 the next cycle.
- Reset asserted in WAIT, then a late rvalid arrives in IDLE:
  - The response is ignored; the buffer stays empty and the first fetch is at pc_in.
